serial_rx: RTL and testbench
============================

# serial_rx

Framed serial receiver: the receive end of the team's serial shift-register link. Samples one line bit per `enable` strobe and recognises an idle-high frame (start bit 0, `n` data bits LSB first, stop bit 1). Assembles the data by shifting right into the MSB and presents it on a parallel output with a ready/ack handshake. Sits between the serial line, or a bit-rate strobe generator, and the parallel consumer, such as a register file or processor input port.

## Interface

- `n`, 8, data bits per frame (≥2)
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  bit strobe; line sampled only on edges where `enable`=1
- `bit_in`  in  1  serial line, idle level 1
- `ack`  in  1  consumer has taken `q`; clears `rdy`
- `q`  out  n  last accepted frame data
- `rdy`  out  1  `q` holds unacknowledged data
- `busy`  out  1  a frame is in progress (state ≠ IDLE)
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0
- `overrun`  out  1  one-cycle pulse: valid frame completed while `rdy`=1 and no `ack`

## Operation

- Reset values: all outputs 0, state IDLE, bit counter 0, shift register 0.
- All sampling is gated by `enable`. On edges with `enable`=0, state, counter and shift register hold. `ack` is honoured on every edge.
- State IDLE: `bit_in`=0 → DATA, counter cleared. `bit_in`=1 → stay.
- State DATA: shift register ← {`bit_in`, sr[n-1:1]}, counter+1. After the n-th data bit → STOP.
- State STOP: `bit_in`=1 gives a valid frame → IDLE.
  - If `rdy`=0 or `ack`=1: `q` ← sr, `rdy` ← 1.
  - Otherwise: `q` unchanged, `overrun` pulses, new data is discarded.
- State STOP: `bit_in`=0 → `frame_err` pulses, `q`/`rdy` unchanged, → WAIT_IDLE.
- State WAIT_IDLE: `bit_in`=1 → IDLE. Zero → stay. The receiver never re-synchronises on a low line.
- `ack`=1 with no completion on the same edge → `rdy` ← 0. `ack` while `rdy`=0 has no effect.
- Completion and `ack` on the same edge: the ack applies first, the new data is loaded, `rdy` stays 1, and there is no overrun.
- Counter width is clog2(n+1). It is never compared beyond n-1 and does not wrap.
- `busy` is combinational from state.

## Timing

- With `enable` held 1, the start bit is sampled at edge 0, data bits at edges 1..n, and the stop bit at edge n+1.
- `q`/`rdy`/`frame_err`/`overrun` are registered at edge n+1 and visible one clock after the stop sample.
- A back-to-back frame can start at edge n+2.
- Pulses (`frame_err`, `overrun`) last exactly one clock regardless of `enable`.
- Reset asserted mid-frame clears everything immediately, without waiting for the clock. The partial frame is lost, and the receiver resumes in IDLE on the first edge after deassertion.

## Structure

- Shared package `serial_pkg`:
  - state encoding localparams IDLE/DATA/STOP/WAIT_IDLE (2 bits)
  - constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1
  - default frame width 8
- One sub-module, `rx_shifter`:
  - n-bit serial-in-at-MSB right shifter
  - shift-enable and clear inputs, async reset
- The FSM, counter and handshake stay in `serial_rx`.

## Test plan

- n=8, `enable`=1, line bits 0,1,0,1,0,0,1,0,1,1 (0xA5 LSB first) → after the stop edge `q`=0xA5, `rdy`=1. `busy` is 1 for edges 1..9 only.
- Same frame with stop=0 → `frame_err` high one clock, `rdy`=0, `busy`=1 until a 1 is sampled, then a following 0x3C frame is received correctly.
- Frame 0x11 not acked, then frame 0x22 → `overrun` pulses, `q` stays 0x11. Ack, then frame 0x33 → `q`=0x33, no overrun.
- `ack` asserted on the exact edge frame 0x44 completes while `rdy`=1 → `q`=0x44, `rdy`=1, `overrun`=0.
- `enable` toggled 1-of-3 cycles during frame 0xC3 → same result as continuous enable. Line and ack changes during `enable`=0 cycles are ignored except `ack`.
- Async reset pulse mid-data (after 4 bits), then frame 0x5A → outputs zero during reset, then `q`=0x5A, `rdy`=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial shift-register link: FSM encoding and line levels.
// Latency: n/a (constants only).
// Backpressure: n/a.
package serial_pkg;

  // Receiver FSM encoding (2 bits)
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] DATA      = 2'd1;
  localparam logic [1:0] STOP      = 2'd2;
  localparam logic [1:0] WAIT_IDLE = 2'd3;

  // Line levels
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Default number of data bits per frame
  localparam int DEFAULT_N = 8;

endpackage

// File: rtl/rx_shifter.sv
// Serial-in-at-MSB right shifter that assembles an LSB-first data word.
// Latency: one clock per shifted bit.
// Backpressure: none; shifts whenever shift is asserted, clear takes priority.
module rx_shifter
  import serial_pkg::*;
#(
  parameter int W = DEFAULT_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         shift,
  input  logic         clear,
  input  logic         din,
  output logic [W-1:0] q
);

  // Shift the new bit in at the MSB so the first received bit ends up at bit 0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= '0;
    end else if (shift) begin
      q <= {din, q[W-1:1]};
    end
  end

endmodule

// File: rtl/serial_rx.sv
// Framed serial receiver: idle-high line, start 0, n data bits LSB first, stop 1; parallel q with rdy/ack.
// Latency: q/rdy/pulses registered on the stop-bit sample edge, visible one clock after it.
// Backpressure: none on the line; a valid frame arriving while rdy is unacknowledged is dropped and flagged by overrun.
module serial_rx
  import serial_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         bit_in,
  input  logic         ack,
  output logic [n-1:0] q,
  output logic         rdy,
  output logic         busy,
  output logic         frame_err,
  output logic         overrun
);

  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(n - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [n-1:0]  sr;
  logic          sr_shift;
  logic          sr_clear;

  // Shift only while collecting data; wipe the register when a start bit is seen
  assign sr_shift = enable && (state == DATA);
  assign sr_clear = enable && (state == IDLE) && (bit_in == START_BIT);

  assign busy = (state != IDLE);

  rx_shifter #(
    .W(n)
  ) u_shifter (
    .clock(clock),
    .reset(reset),
    .shift(sr_shift),
    .clear(sr_clear),
    .din  (bit_in),
    .q    (sr)
  );

  // Frame FSM and bit counter, advanced only on enable strobes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (bit_in == START_BIT) begin
            state <= DATA;
            cnt   <= '0;
          end
        end
        DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            state <= STOP;
          end
        end
        STOP: begin
          state <= (bit_in == STOP_BIT) ? IDLE : WAIT_IDLE;
        end
        default: begin
          // A line stuck low after a bad stop bit must return high before the next start
          if (bit_in == LINE_IDLE) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Output handshake: ack is honoured every edge, completion overrides it and reloads q
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q         <= '0;
      rdy       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (ack) begin
        rdy <= 1'b0;
      end
      if (enable && (state == STOP)) begin
        if (bit_in == STOP_BIT) begin
          if (!rdy || ack) begin
            q   <= sr;
            rdy <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Randomised frame-level bench for serial_rx with a scoreboard fed by a frame-level reference model.
// Latency: checks every completion event on the clock after its stop sample.
// Backpressure: exercises unacked overrun, same-edge ack, and ack during gated cycles.
module tb_serial_rx;

  localparam int N = 8;
  localparam logic [1:0] K_LOAD = 2'd0;
  localparam logic [1:0] K_OVR  = 2'd1;
  localparam logic [1:0] K_ERR  = 2'd2;

  typedef struct packed {
    logic [1:0]   kind;
    logic [N-1:0] q;
    logic         rdy;
  } exp_t;

  logic         clock;
  logic         reset;
  logic         enable;
  logic         bit_in;
  logic         ack;
  logic [N-1:0] q;
  logic         rdy;
  logic         busy;
  logic         frame_err;
  logic         overrun;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];

  // frame-level model of the consumer-visible state
  logic [N-1:0] q_m;
  logic         rdy_m;

  serial_rx #(.n(N)) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .bit_in   (bit_in),
    .ack      (ack),
    .q        (q),
    .rdy      (rdy),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic drive(input logic e, input logic b, input logic a);
    enable = e;
    bit_in = b;
    ack    = a;
    @(posedge clock);
    #1;
    enable = 1'b0;
    ack    = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b1, 1'b1, 1'b0);
  endtask

  // ack pulse on its own cycle, enable either level: rdy must drop
  task automatic ack_pulse(input logic e);
    drive(e, e ? 1'b1 : 1'(($urandom & 1)), 1'b1);
    rdy_m = 1'b0;
    chk("rdy_after_ack", rdy, rdy_m);
  endtask

  task automatic send_frame(input logic [N-1:0] d, input logic stop, input logic ack_s,
                            input int gmin, input int gmax);
    exp_t  e;
    logic  bv;
    if (stop) begin
      if (!rdy_m || ack_s) begin
        q_m   = d;
        rdy_m = 1'b1;
        e.kind = K_LOAD;
      end else begin
        e.kind = K_OVR;
      end
    end else begin
      if (ack_s) rdy_m = 1'b0;
      e.kind = K_ERR;
    end
    e.q   = q_m;
    e.rdy = rdy_m;
    exp_q.push_back(e);
    for (int i = 0; i <= N + 1; i++) begin
      if (i == 0) bv = 1'b0;
      else if (i <= N) bv = d[i-1];
      else bv = stop;
      for (int g = 0; g < $urandom_range(gmax, gmin); g++)
        drive(1'b0, 1'(($urandom & 1)), 1'b0);
      drive(1'b1, bv, (i == N + 1) ? ack_s : 1'b0);
      if (i == 0) chk("busy_after_start", busy, 1);
    end
  endtask

  // Monitor: every completion/pulse is matched against the next scoreboard entry
  logic prev_busy = 1'b0;
  logic in_err    = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    logic ev;
    if (reset) begin
      prev_busy <= 1'b0;
      in_err    <= 1'b0;
    end else begin
      ev = (prev_busy && !busy && !in_err) || frame_err || overrun;
      if (prev_busy && !busy && in_err && !frame_err) in_err <= 1'b0;
      if (frame_err) in_err <= 1'b1;
      if (ev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("q", q, e.q);
          chk("rdy", rdy, e.rdy);
          chk("overrun", overrun, e.kind == K_OVR);
          chk("frame_err", frame_err, e.kind == K_ERR);
          chk("busy_at_event", busy, e.kind == K_ERR);
        end
      end
      prev_busy <= busy;
    end
  end

  initial begin
    logic [N-1:0] d;
    logic         st;
    reset  = 1'b1;
    enable = 1'b0;
    bit_in = 1'b1;
    ack    = 1'b0;
    q_m    = '0;
    rdy_m  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_q", q, 0);
    chk("reset_rdy", rdy, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    reset = 1'b0;
    idle(2);

    // basic frame, then bad stop, recovery and a good frame
    send_frame(8'hA5, 1'b1, 1'b0, 0, 0);
    idle(1);
    chk("busy_idle", busy, 0);
    ack_pulse(1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 1'b0);
    chk("busy_wait_idle", busy, 1);
    idle(2);
    send_frame(8'h3C, 1'b1, 1'b0, 0, 0);

    // overrun then recovery
    ack_pulse(1'b1);
    send_frame(8'h11, 1'b1, 1'b0, 0, 0);
    send_frame(8'h22, 1'b1, 1'b0, 0, 0);
    ack_pulse(1'b1);
    send_frame(8'h33, 1'b1, 1'b0, 0, 0);

    // ack on the completing edge while rdy=1
    send_frame(8'h44, 1'b1, 1'b1, 0, 0);

    // gated enable 1-of-3 with ack during a disabled cycle
    ack_pulse(1'b0);
    send_frame(8'hC3, 1'b1, 1'b0, 2, 2);
    idle(1);

    // async reset after 4 data bits
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'(($urandom & 1)), 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("midreset_q", q, 0);
    chk("midreset_rdy", rdy, 0);
    chk("midreset_busy", busy, 0);
    @(posedge clock);
    #1;
    chk("midreset_hold_busy", busy, 0);
    reset = 1'b0;
    q_m   = '0;
    rdy_m = 1'b0;
    send_frame(8'h5A, 1'b1, 1'b0, 0, 0);

    // random traffic
    for (int f = 0; f < 60; f++) begin
      d  = N'($urandom);
      st = ($urandom_range(5, 0) != 0);
      if ($urandom & 1) ack_pulse(1'(($urandom & 1)));
      send_frame(d, st, ($urandom_range(3, 0) == 0), 0, 2);
      idle(st ? $urandom_range(2, 0) : $urandom_range(2, 1));
    end

    // drain
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
    repeat (2) @(posedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
